// File: rtl/timer_irq_host.sv
// rtl/timer_irq_host.sv - Avalon-MM host that arms the interval timer irq and turns each timeout into a tick
module timer_irq_host #(
  parameter int CNT_W     = 32,
  parameter int STATUS_TO = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             restart,
  output logic [2:0]       address,
  output logic             chipselect,
  output logic             write_n,
  output logic [15:0]      writedata,
  input  logic [15:0]      readdata,
  input  logic             irq,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic             spurious_err,
  output logic             busy
);

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_PERL   = 3'd2;

  typedef enum logic [2:0] {
    CTRL_WR,
    IDLE,
    RESTART,
    RD_ADDR,
    RD_WAIT,
    CLEAR
  } state_t;

  state_t state, next_state;
  logic   enable_q;
  logic   ctrl_shadow;
  logic   restart_pend;
  logic   irq_mask;
  logic   status_to;
  logic   unused_readdata;

  assign status_to       = readdata[STATUS_TO];
  assign unused_readdata = ^readdata;

  // Left without reset so the value written right after reset already reflects enable.
  always_ff @(posedge clk) begin
    enable_q <= enable;
  end

  // Bus outputs are registered from next_state, so each state's bus cycle is visible
  // while that state is current. Out of reset the write is not on the bus yet, so
  // CTRL_WR holds until its chipselect has actually been seen.
  always_comb begin
    next_state = state;
    case (state)
      CTRL_WR: if (chipselect) next_state = IDLE;
      IDLE: begin
        if (enable_q != ctrl_shadow)               next_state = CTRL_WR;
        else if (restart_pend)                     next_state = RESTART;
        else if (irq && enable_q && !irq_mask)     next_state = RD_ADDR;
      end
      RESTART: next_state = IDLE;
      RD_ADDR: next_state = RD_WAIT;
      RD_WAIT: next_state = status_to ? CLEAR : IDLE;
      CLEAR:   next_state = IDLE;
      default: next_state = CTRL_WR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= CTRL_WR;
      address      <= 3'd0;
      chipselect   <= 1'b0;
      write_n      <= 1'b1;
      writedata    <= 16'h0000;
      tick         <= 1'b0;
      tick_count   <= '0;
      spurious_err <= 1'b0;
      busy         <= 1'b1;
      ctrl_shadow  <= 1'b0;
      restart_pend <= 1'b0;
      irq_mask     <= 1'b0;
    end else begin
      state        <= next_state;
      busy         <= (next_state != IDLE);
      chipselect   <= (next_state != IDLE);
      write_n      <= !(next_state == CTRL_WR || next_state == RESTART || next_state == CLEAR);
      tick         <= (next_state == CLEAR);
      irq_mask     <= (state == CLEAR);
      restart_pend <= restart || (restart_pend && (state != RESTART));
      case (next_state)
        CTRL_WR: address <= ADDR_CTRL;
        RESTART: address <= ADDR_PERL;
        default: address <= ADDR_STATUS;
      endcase
      if (next_state == CTRL_WR) begin
        writedata   <= {15'b0, enable_q};
        ctrl_shadow <= enable_q;
      end else begin
        writedata   <= 16'h0000;
      end
      if (next_state == CLEAR)
        tick_count <= tick_count + CNT_W'(1);
      // Status read came back without TO although irq was asserted.
      if (state == RD_WAIT && !status_to)
        spurious_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_timer_irq_host.sv
// tb/tb_timer_irq_host.sv - randomized scoreboard bench for timer_irq_host with a behavioural timer slave
`timescale 1ns/1ps
module tb_timer_irq_host;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b1;
  logic             restart = 1'b0;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [15:0]      writedata;
  logic [15:0]      readdata = 16'h0000;
  logic             irq;
  logic             tick;
  logic [CNT_W-1:0] tick_count;
  logic             spurious_err;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // Timer slave: TO set by stimulus, cleared by a status write; irq = TO & ITO.
  logic ctrl_ito = 1'b0, to_bit = 1'b0, to_pulse = 1'b0, to_kill = 1'b0, spur_irq = 1'b0;
  assign irq = (to_bit && ctrl_ito) || spur_irq;

  always #5 clk = ~clk;

  timer_irq_host #(.CNT_W(CNT_W), .STATUS_TO(0)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .restart(restart),
    .address(address), .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .irq(irq), .tick(tick), .tick_count(tick_count),
    .spurious_err(spurious_err), .busy(busy)
  );

  always @(posedge clk) begin
    readdata <= (chipselect && write_n && address == 3'd0) ? {14'b0, 1'b1, to_bit} : 16'h0000;
    if (chipselect && !write_n && address == 3'd1) ctrl_ito <= writedata[0];
    if ((chipselect && !write_n && address == 3'd0) || to_kill) to_bit <= 1'b0;
    else if (to_pulse) to_bit <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard queues of expected bus writes, one per target register.
  logic [15:0] ctrl_q[$];
  logic [15:0] rst_q[$];
  logic [15:0] clr_q[$];
  int   exp_cnt = 0;
  int   act_reads = 0;
  int   exp_reads = 0;
  logic in_read = 1'b0;
  logic en_model = 1'b1;
  logic sp_exp = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_cnt = 0;
      in_read = 1'b0;
    end else begin
      if (chipselect && !write_n) begin
        if (address == 3'd1) begin
          check("ctrl write expected", ctrl_q.size() > 0, 1);
          if (ctrl_q.size() > 0) check("ctrl writedata", writedata, ctrl_q.pop_front());
        end else if (address == 3'd2) begin
          check("restart write expected", rst_q.size() > 0, 1);
          if (rst_q.size() > 0) check("restart writedata", writedata, rst_q.pop_front());
        end else if (address == 3'd0) begin
          check("clear write expected", clr_q.size() > 0, 1);
          if (clr_q.size() > 0) begin
            check("clear writedata", writedata, clr_q.pop_front());
            exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
            check("tick with clear", tick, 1);
            check("tick_count", tick_count, exp_cnt);
          end
        end else begin
          check("write address", address, 0);
        end
      end else if (tick) begin
        check("tick only with clear", tick, 0);
      end
      if (chipselect && write_n && !in_read) begin
        act_reads++;
        check("read address", address, 0);
      end
      in_read = chipselect && write_n;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_timeout();
    to_pulse = 1'b1;
    cyc(1);
    to_pulse = 1'b0;
    if (en_model) begin
      clr_q.push_back(16'h0000);
      exp_reads++;
    end else begin
      cyc(4);
      to_kill = 1'b1;
      cyc(1);
      to_kill = 1'b0;
    end
  endtask

  task automatic do_spurious();
    spur_irq = 1'b1;
    if (en_model) begin
      exp_reads++;
      sp_exp = 1'b1;
      for (int i = 0; i < 20 && !(chipselect && write_n); i++) cyc(1);
    end else begin
      cyc(5);
    end
    spur_irq = 1'b0;
  endtask

  task automatic do_restart(input int pulses);
    rst_q.push_back(16'h0000);
    for (int i = 0; i < pulses; i++) begin
      restart = 1'b1;
      cyc(1);
      restart = 1'b0;
      cyc(1);
    end
  endtask

  task automatic do_toggle();
    enable = !enable;
    en_model = enable;
    ctrl_q.push_back({15'b0, enable});
  endtask

  task automatic settle(input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 6 && n < 300) begin
      cyc(1);
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    check({tag, " returned to idle"}, quiet >= 6, 1);
    check({tag, " ctrl_q drained"}, ctrl_q.size(), 0);
    check({tag, " rst_q drained"}, rst_q.size(), 0);
    check({tag, " clr_q drained"}, clr_q.size(), 0);
    check({tag, " read count"}, act_reads, exp_reads);
    check({tag, " spurious_err"}, spurious_err, sp_exp);
  endtask

  initial begin
    int n;
    int op;
    ctrl_q.push_back(16'h0001);
    cyc(2);
    check("reset address", address, 0);
    check("reset chipselect", chipselect, 0);
    check("reset write_n", write_n, 1);
    check("reset writedata", writedata, 0);
    check("reset tick", tick, 0);
    check("reset tick_count", tick_count, 0);
    check("reset spurious_err", spurious_err, 0);
    check("reset busy", busy, 1);
    reset_n = 1'b1;

    n = 0;
    while (!(chipselect && !write_n) && n < 10) begin
      cyc(1);
      n++;
    end
    check("first op address", address, 1);
    check("first op writedata", writedata, 16'h0001);
    cyc(1);
    check("busy after ctrl write", busy, 0);
    check("bus idle after ctrl write", chipselect, 0);
    settle("init");

    repeat (18) begin
      do_timeout();
      settle("timeout");
    end
    do_spurious();
    settle("spurious");

    repeat (60) begin
      op = int'($urandom_range(0, 5));
      case (op)
        0, 1: do_timeout();
        2:    do_spurious();
        3:    do_restart(1);
        4:    do_toggle();
        default: begin
          if (en_model) begin
            do_timeout();
            do_restart(2);
          end else begin
            do_timeout();
          end
        end
      endcase
      settle("random");
    end

    if (!en_model) begin
      do_toggle();
      settle("re-enable");
    end

    // Reset in the middle of a status read: host must drop the bus and start over.
    ctrl_q.push_back(16'h0001);
    clr_q.push_back(16'h0000);
    exp_reads += 2;
    to_pulse = 1'b1;
    cyc(1);
    to_pulse = 1'b0;
    n = 0;
    while (!(chipselect && write_n) && n < 20) begin
      cyc(1);
      n++;
    end
    check("read seen before reset", chipselect && write_n, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async reset chipselect", chipselect, 0);
    check("async reset write_n", write_n, 1);
    check("async reset busy", busy, 1);
    check("async reset tick_count", tick_count, 0);
    check("async reset spurious_err", spurious_err, 0);
    sp_exp = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    settle("post reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
